// File: rtl/ov7670_cfg_pkg.sv
// Shared types and constants for the OV7670 register-init sequencer and its table ROM.
package ov7670_cfg_pkg;

    localparam logic [7:0]  SCCB_ID_DEFAULT = 8'h42;
    localparam logic [15:0] END_MARK        = 16'hFFFF;
    localparam logic [15:0] DEL_MARK        = 16'hFFF0;

    // Table contents selectable per instance: real camera list, short bring-up list, all-writes fill.
    localparam int TBL_OV7670 = 0;
    localparam int TBL_SHORT  = 1;
    localparam int TBL_FILL   = 2;

    typedef enum logic [2:0] {
        PWRUP,
        FETCH,
        DECODE,
        SEND,
        DELAY,
        DONE
    } cfg_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ov7670_reg_rom.sv
// Synchronous {register,value} table ROM; data appears one clock after the address.
module ov7670_reg_rom
    import ov7670_cfg_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int TABLE_SEL = TBL_OV7670
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [15:0]       data_o
);

    localparam int DEPTH = 1 << ADDR_W;

    function automatic logic [15:0] table_entry(input int idx);
        logic [15:0] e;
        e = END_MARK;
        case (TABLE_SEL)
            TBL_SHORT: begin
                case (idx)
                    0:       e = 16'h1280;
                    1:       e = DEL_MARK;
                    2:       e = 16'h40D0;
                    default: e = END_MARK;
                endcase
            end
            TBL_FILL: e = {8'(idx), ~8'(idx)};
            default: begin
                // Soft reset first, then let the sensor settle before the real setup.
                case (idx)
                    0:       e = 16'h1280;
                    1:       e = DEL_MARK;
                    2:       e = 16'h1204;
                    3:       e = 16'h1180;
                    4:       e = 16'h0C00;
                    5:       e = 16'h3E00;
                    6:       e = 16'h0400;
                    7:       e = 16'h40D0;
                    8:       e = 16'h3A04;
                    9:       e = 16'h1418;
                    10:      e = 16'h4FB3;
                    11:      e = 16'h50B3;
                    12:      e = 16'h5100;
                    13:      e = 16'h523D;
                    14:      e = 16'h53A7;
                    15:      e = 16'h54E4;
                    16:      e = 16'h589E;
                    17:      e = 16'h3DC0;
                    18:      e = 16'h1714;
                    19:      e = 16'h1802;
                    20:      e = 16'h3280;
                    21:      e = 16'h1903;
                    22:      e = 16'h1A7B;
                    23:      e = 16'h030A;
                    24:      e = 16'h0F41;
                    25:      e = 16'h1E00;
                    26:      e = 16'h330B;
                    27:      e = 16'h3C78;
                    28:      e = 16'h6900;
                    29:      e = 16'h7400;
                    30:      e = 16'hB084;
                    31:      e = 16'hB10C;
                    32:      e = 16'hB20E;
                    33:      e = 16'hB380;
                    default: e = END_MARK;
                endcase
            end
        endcase
        return e;
    endfunction

    logic [15:0] rom_mem [DEPTH];
    logic [15:0] data_q;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
            assign rom_mem[gi] = table_entry(gi);
        end
    endgenerate

    always_ff @(posedge clk) begin
        data_q <= rom_mem[addr_i];
    end

    assign data_o = data_q;

endmodule

// File: rtl/ov7670_config_seq.sv
// Camera register-init sequencer: walks the table ROM and hands each {reg,val}
// to the SCCB sender over a send/taken level handshake, with power-up and table delays.
module ov7670_config_seq
    import ov7670_cfg_pkg::*;
#(
    parameter logic [7:0] SCCB_ID        = SCCB_ID_DEFAULT,
    parameter int         PWRUP_CYCLES   = 1_250_000,
    parameter int         DELAY_CYCLES   = 500_000,
    parameter int         TIMEOUT_CYCLES = 65_536,
    parameter int         ADDR_W         = 8,
    parameter int         TABLE_SEL      = TBL_OV7670
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              restart,
    input  logic              taken,
    output logic              send,
    output logic [7:0]        id,
    output logic [7:0]        reg_addr,
    output logic [7:0]        reg_val,
    output logic              config_done,
    output logic              config_err,
    output logic [ADDR_W-1:0] cfg_index
);

    localparam int MAX_CYC = max3(PWRUP_CYCLES, DELAY_CYCLES, TIMEOUT_CYCLES);
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0]  PWRUP_LAST   = CNT_W'(PWRUP_CYCLES - 1);
    localparam logic [CNT_W-1:0]  DELAY_LAST   = CNT_W'(DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_W-1:0] INDEX_LAST   = '1;

    cfg_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [7:0]        addr_q, addr_d;
    logic [7:0]        val_q, val_d;
    logic              err_q, err_d;
    logic [15:0]       rom_data;
    logic              last_entry;

    ov7670_reg_rom #(
        .ADDR_W    (ADDR_W),
        .TABLE_SEL (TABLE_SEL)
    ) u_rom (
        .clk    (clk),
        .addr_i (index_q),
        .data_o (rom_data)
    );

    assign last_entry = (index_q == INDEX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PWRUP;
            cnt_q   <= '0;
            index_q <= '0;
            addr_q  <= '0;
            val_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            index_q <= index_d;
            addr_q  <= addr_d;
            val_q   <= val_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        index_d = index_q;
        addr_d  = addr_q;
        val_d   = val_q;
        err_d   = err_q;
        unique case (state_q)
            PWRUP: begin
                if (cnt_q == PWRUP_LAST) begin
                    cnt_d   = '0;
                    state_d = FETCH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FETCH: state_d = DECODE;
            DECODE: begin
                if (rom_data == END_MARK) begin
                    state_d = DONE;
                end else if (rom_data == DEL_MARK) begin
                    cnt_d   = '0;
                    state_d = DELAY;
                end else begin
                    addr_d  = rom_data[15:8];
                    val_d   = rom_data[7:0];
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                // taken wins over a coincident timeout: the frame was accepted.
                if (taken) begin
                    state_d = last_entry ? DONE : FETCH;
                    index_d = last_entry ? index_q : index_q + 1'b1;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DELAY: begin
                if (cnt_q == DELAY_LAST) begin
                    state_d = last_entry ? DONE : FETCH;
                    index_d = last_entry ? index_q : index_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (restart) begin
                    index_d = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = PWRUP;
                end
            end
            default: state_d = PWRUP;
        endcase
    end

    always_comb begin
        send        = (state_q == SEND);
        config_done = (state_q == DONE);
    end

    assign id         = SCCB_ID;
    assign reg_addr   = addr_q;
    assign reg_val    = val_q;
    assign config_err = err_q;
    assign cfg_index  = index_q;

endmodule

// File: tb/tb_ov7670_config_seq.sv
// Directed bench for ov7670_config_seq: short table with a sender model, slow/absent
// sender, restart and async reset behaviour, plus a 256-entry no-END table instance.
module tb_ov7670_config_seq;
    import ov7670_cfg_pkg::*;

    localparam int PW = 10;
    localparam int DL = 20;
    localparam int TO = 50;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       restart = 1'b0;
    logic       model_taken = 1'b0;
    logic       stray_taken = 1'b0;
    logic       taken;
    logic       send;
    logic [7:0] id, reg_addr, reg_val;
    logic       config_done, config_err;
    logic [7:0] cfg_index;

    logic       rst_w_n = 1'b1;
    logic       taken_w = 1'b0;
    logic       send_w;
    logic [7:0] id_w, reg_addr_w, reg_val_w;
    logic       done_w, err_w;
    logic [7:0] idx_w;

    int checks = 0;
    int errors = 0;
    int taken_delay = 5;
    int cyc = 0;
    int writes = 0;
    int wrap_writes = 0;
    int accepts = 0;

    logic [15:0] exp_q[$];
    logic [15:0] wrap_q[$];

    assign taken = model_taken | stray_taken;

    always #5 clk = ~clk;

    ov7670_config_seq #(
        .PWRUP_CYCLES   (PW),
        .DELAY_CYCLES   (DL),
        .TIMEOUT_CYCLES (TO),
        .ADDR_W         (8),
        .TABLE_SEL      (TBL_SHORT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .restart     (restart),
        .taken       (taken),
        .send        (send),
        .id          (id),
        .reg_addr    (reg_addr),
        .reg_val     (reg_val),
        .config_done (config_done),
        .config_err  (config_err),
        .cfg_index   (cfg_index)
    );

    ov7670_config_seq #(
        .PWRUP_CYCLES   (PW),
        .DELAY_CYCLES   (DL),
        .TIMEOUT_CYCLES (TO),
        .ADDR_W         (8),
        .TABLE_SEL      (TBL_FILL)
    ) dut_wrap (
        .clk         (clk),
        .rst_n       (rst_w_n),
        .restart     (1'b0),
        .taken       (taken_w),
        .send        (send_w),
        .id          (id_w),
        .reg_addr    (reg_addr_w),
        .reg_val     (reg_val_w),
        .config_done (done_w),
        .config_err  (err_w),
        .cfg_index   (idx_w)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sender model: raises taken for one cycle after send has been high taken_delay cycles.
    initial begin
        int hi;
        hi = 0;
        forever begin
            @(posedge clk); #1;
            if (model_taken) begin
                model_taken = 1'b0;
                hi = 0;
            end else if (send && taken_delay > 0) begin
                hi++;
                if (hi >= taken_delay) model_taken = 1'b1;
            end else begin
                hi = 0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            taken_w = send_w && !taken_w;
        end
    end

    always @(posedge clk) begin
        if (taken && send) accepts <= accepts + 1;
    end

    // Scoreboard for the short-table instance.
    initial begin
        logic        send_prev;
        logic        unstable;
        logic [15:0] cap;
        send_prev = 1'b0;
        unstable  = 1'b0;
        cap       = '0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (send && !send_prev) begin
                writes++;
                cap = {reg_addr, reg_val};
                unstable = 1'b0;
                $display("[cyc %0d] write %0d reg=%02h val=%02h", cyc, writes, reg_addr, reg_val);
                chk("sb_nonempty", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) chk("sb_write", {reg_addr, reg_val}, exp_q.pop_front());
            end else if (send && send_prev && {reg_addr, reg_val} != cap) begin
                unstable = 1'b1;
            end
            if (!send && send_prev) chk("send_data_stable", unstable, 0);
            send_prev = send;
        end
    end

    initial begin
        logic send_prev;
        send_prev = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (send_w && !send_prev) begin
                wrap_writes++;
                $display("[cyc %0d] wrap write %0d reg=%02h val=%02h", cyc, wrap_writes, reg_addr_w, reg_val_w);
                chk("wrap_sb_nonempty", 32'(wrap_q.size() > 0), 1);
                if (wrap_q.size() > 0) chk("wrap_sb_write", {reg_addr_w, reg_val_w}, wrap_q.pop_front());
            end
            send_prev = send_w;
        end
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return send;
            1:       return config_done;
            default: return done_w;
        endcase
    endfunction

    task automatic wait_for(input int sel, input logic lvl, input int budget, input string tag);
        int n;
        n = 0;
        while (sig(sel) !== lvl && n < budget) begin
            tick();
            n++;
        end
        chk(tag, sig(sel), lvl);
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    task automatic check_latency(input string tag);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= PW + 2; c++) begin
            @(posedge clk); #2;
            stray_taken = (c == 3);
            if (c == PW + 1) chk({tag, "_send_low"}, send, 0);
        end
        stray_taken = 1'b0;
        chk({tag, "_send_rise"}, send, 1);
        chk({tag, "_index"}, cfg_index, 0);
    endtask

    initial begin
        int f;
        int r;
        int w0;
        int a0;

        #1;
        rst_n = 1'b0;
        rst_w_n = 1'b0;
        repeat (3) tick();
        chk("rst_send", send, 0);
        chk("rst_reg_addr", reg_addr, 0);
        chk("rst_reg_val", reg_val, 0);
        chk("rst_done", config_done, 0);
        chk("rst_err", config_err, 0);
        chk("rst_index", cfg_index, 0);
        chk("rst_id", id, 8'h42);

        // Short table with a stray taken during the power-up wait.
        exp_q.push_back(16'h1280);
        exp_q.push_back(16'h40D0);
        check_latency("first");
        wait_for(0, 0, 20, "first_taken");
        f = cyc;
        chk("index_after_first", cfg_index, 1);
        wait_for(0, 1, 100, "second_send");
        chk("delay_gap_ge_20", 32'((cyc - f) >= DL), 1);
        wait_for(1, 1, 50, "short_done");
        chk("short_writes", writes, 2);
        chk("short_accepts", accepts, 2);
        chk("short_err", config_err, 0);
        chk("short_index", cfg_index, 3);
        chk("short_send_low", send, 0);
        chk("short_sb_empty", exp_q.size(), 0);

        // Slow sender plus a restart during SEND that must be ignored.
        taken_delay = 30;
        w0 = writes;
        a0 = accepts;
        exp_q.push_back(16'h1280);
        exp_q.push_back(16'h40D0);
        pulse_restart();
        chk("restart_clears_done", config_done, 0);
        chk("restart_index", cfg_index, 0);
        wait_for(0, 1, 40, "slow_send");
        pulse_restart();
        chk("restart_in_send_send", send, 1);
        chk("restart_in_send_index", cfg_index, 0);
        wait_for(1, 1, 300, "slow_done");
        chk("slow_writes", writes - w0, 2);
        chk("slow_accepts", accepts - a0, 2);

        // Sender that never answers.
        taken_delay = 0;
        a0 = accepts;
        exp_q.push_back(16'h1280);
        pulse_restart();
        wait_for(0, 1, 40, "to_send");
        r = cyc;
        wait_for(0, 0, 100, "to_drop");
        chk("timeout_len", cyc - r, TO);
        chk("timeout_err", config_err, 1);
        chk("timeout_done", config_done, 1);
        chk("timeout_accepts", accepts - a0, 0);
        taken_delay = 5;
        w0 = writes;
        exp_q.push_back(16'h1280);
        exp_q.push_back(16'h40D0);
        pulse_restart();
        chk("rerun_err_cleared", config_err, 0);
        chk("rerun_done_cleared", config_done, 0);
        wait_for(1, 1, 200, "rerun_done");
        chk("rerun_err", config_err, 0);
        chk("rerun_writes", writes - w0, 2);

        // Asynchronous reset in the middle of a write.
        taken_delay = 0;
        exp_q.push_back(16'h1280);
        pulse_restart();
        wait_for(0, 1, 40, "rst_mid_send");
        repeat (3) tick();
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_send", send, 0);
        chk("async_reg_addr", reg_addr, 0);
        chk("async_reg_val", reg_val, 0);
        chk("async_done", config_done, 0);
        chk("async_index", cfg_index, 0);
        repeat (2) tick();
        taken_delay = 5;
        exp_q.push_back(16'h1280);
        exp_q.push_back(16'h40D0);
        check_latency("after_rst");
        wait_for(1, 1, 200, "after_rst_done");
        chk("after_rst_sb_empty", exp_q.size(), 0);

        // 256 write entries and no END marker: must stop after entry 255.
        for (int i = 0; i < 256; i++) wrap_q.push_back({8'(i), ~8'(i)});
        @(negedge clk);
        rst_w_n = 1'b1;
        wait_for(2, 1, 3000, "wrap_done");
        chk("wrap_writes", wrap_writes, 256);
        chk("wrap_index", idx_w, 8'hFF);
        chk("wrap_err", err_w, 0);
        chk("wrap_sb_empty", wrap_q.size(), 0);
        repeat (30) tick();
        chk("no_wrap_writes", wrap_writes, 256);
        chk("no_wrap_send", send_w, 0);
        chk("no_wrap_done", done_w, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
